rng_arbiter: RTL
================

Name: rng_arbiter

Overview:
- Controller and round-robin arbiter that shares one 16-bit LFSR random source among N stochastic-neuron requesters in the neuromorphic processor.
- Owns the LFSR enable: it sequences IDLE -> WARMUP -> RUN, discards the low-entropy words that follow a reseed, and then issues at most one random word per cycle.
- Because only one word is issued per cycle, no two requesters ever receive the same LFSR state.
- Sits between the external lfsr block (enable out, word in) and the neuron update units.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- LFSR_LEN, 16, width of the LFSR word input.
- RAND_W, 8, width of the word issued to requesters (RAND_W <= LFSR_LEN); the issued word is lfsr_out[RAND_W-1:0].
- WARMUP_CYC, 16, LFSR steps discarded after each reseed (1..255).
- CNT_W, 16, width of the issued-word counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- run_en  in  1  level; 1 = generator active, 0 = stop and reseed.
- lfsr_en  out  1  enable to the lfsr block; 0 reseeds it to 1.
- lfsr_out  in  LFSR_LEN  current LFSR word.
- req  in  N_REQ  per-requester request levels.
- gnt  out  N_REQ  one-hot grant pulse, registered.
- rand_data  out  RAND_W  issued word, valid while rand_valid = 1.
- rand_valid  out  1  equals |gnt.
- busy  out  1  1 while in WARMUP or RUN.
- warm  out  1  1 while in RUN.
- issued_cnt  out  CNT_W  number of words issued since reset, wrapping.

Behaviour:
- Reset (asynchronous, reset_n = 0): state = IDLE, all outputs 0, warmup counter = 0, round-robin pointer = 0. Reset takes effect immediately, including mid-warmup or mid-grant.
- All outputs are registered.
- FSM:
  - IDLE: lfsr_en = 0. If run_en = 1, go to WARMUP and clear the warmup counter.
  - WARMUP: lfsr_en = 1, counter increments once per cycle. When counter = WARMUP_CYC-1, go to RUN. If run_en = 0, go to IDLE.
  - RUN: lfsr_en = 1 continuously (the LFSR steps once every cycle, whether or not a grant is made). If run_en = 0, go to IDLE next edge; no grant is issued on that edge.
- lfsr_en is a registered output and is 1 in WARMUP and RUN. The first cycle in which warm = 1 follows exactly WARMUP_CYC cycles with lfsr_en = 1.
- Arbitration (RUN only, evaluated at each posedge):
  - Eligible set = req & ~gnt. A requester granted on one edge cannot be granted on the next edge, so a requester is allowed a one-cycle delay in dropping req.
  - Winner = first eligible index at or after the pointer, searching modulo N_REQ.
  - gnt <= onehot(winner); rand_data <= lfsr_out[RAND_W-1:0] sampled on the same edge; pointer <= (winner+1) mod N_REQ; issued_cnt increments by 1, wrapping at 2^CNT_W.
  - If the eligible set is empty: gnt <= 0, and rand_data and the pointer hold.
- Grant latency: a req first seen at edge t (in RUN, with the pointer at that index) gives gnt = 1 from edge t through edge t+1.
- A requester that keeps req high continuously is granted at most every other cycle, and is also subject to round-robin ordering.
- Fairness: with all requesters continuously active, every requester is granted within N_REQ grants.
- req during IDLE or WARMUP is ignored, not queued; requesters keep req high until they are granted.
- Leaving RUN (run_en = 0 or reset): gnt and rand_valid are 0 from the next edge. The pointer holds across IDLE; only reset clears it.
- Re-entering WARMUP always repeats the full warmup, because lfsr_en = 0 in IDLE reseeds the LFSR.
- run_en toggling 1 -> 0 -> 1 within WARMUP restarts the warmup count from 0.

Decomposition:
- Package rng_pkg: state enum {IDLE, WARMUP, RUN}; default parameter constants; a function next_rr(req_mask, ptr) returning the winner index.
- One natural sub-module, rr_arbiter: N_REQ-wide masked priority search plus pointer register, with a combinational winner output.
- The FSM, warmup counter, data capture and issued counter stay in rng_arbiter.
- The LFSR is instantiated beside rng_arbiter at the top level, not inside it.

Test Plan:
- Reset, then run_en = 1 with N_REQ = 4 and WARMUP_CYC = 16 -> lfsr_en = 1 at the edge after run_en, warm = 1 exactly 16 cycles later; no gnt before that even with req = 4'b1111.
- In RUN, req = 4'b1111 held -> gnt sequence 0001, 0010, 0100, 1000, 0001…; issued_cnt +1 per cycle; each rand_data equals lfsr_out[7:0] sampled on its grant edge, with no repeats across consecutive grants.
- Single req[2] held high -> gnt = 0100 every other cycle, 0000 in between.
- req = 4'b1010 with pointer at 0 -> 0010 granted first, then 1000.
- run_en dropped in RUN while req = 4'b1111 -> gnt = 0 from the next edge, lfsr_en = 0 and state IDLE; run_en reasserted -> full 16-cycle warmup again, and the first issued word matches the first issued word after the initial warmup.
- reset_n pulsed low mid-WARMUP and mid-grant -> all outputs 0 immediately (asynchronous); issued_cnt = 0; first grant after recovery goes to index 0.
- issued_cnt with CNT_W = 4 forced -> wraps 15 -> 0 with no other side effect.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared types, default constants and the round-robin search helper for
// the LFSR random-word arbiter.
package rng_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_e;

  localparam int unsigned DEF_N_REQ      = 4;
  localparam int unsigned DEF_LFSR_LEN   = 16;
  localparam int unsigned DEF_RAND_W     = 8;
  localparam int unsigned DEF_WARMUP_CYC = 16;
  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned MAX_REQ        = 16;

  // First set bit of req_mask at or after ptr, searching modulo n_req.
  // ptr < n_req is assumed, so one conditional subtraction wraps the index.
  // Returns 0 when the mask is empty; callers qualify with |req_mask.
  function automatic logic [3:0] next_rr(input logic [15:0] req_mask,
                                         input logic [3:0]  ptr,
                                         input logic [4:0]  n_req);
    logic [3:0] win;
    logic       found;
    logic [4:0] idx;
    win   = 4'd0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idx = 5'(ptr) + 5'(i);
      if (idx >= n_req) begin
        idx = idx - n_req;
      end else begin
        idx = idx;
      end
      if ((5'(i) < n_req) && !found && req_mask[idx[3:0]]) begin
        win   = idx[3:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rng_arbiter_rr.sv
// Round-robin search over an eligibility mask, with the rotating pointer
// register. The winner is combinational; the pointer moves past the winner
// only when the parent actually takes the grant.
module rr_arbiter
  import rng_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req_mask,
  input  logic                     take,
  output logic                     any_req,
  output logic [$clog2(N_REQ)-1:0] winner
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  assign any_req = |req_mask;
  assign winner  = PTR_W'(next_rr(16'(req_mask), 4'(ptr_q), 5'(N_REQ)));

  // Advance the pointer to the slot after the winner when a grant is taken.
  always_comb begin
    ptr_d = ptr_q;
    if (take && any_req) begin
      if (winner == PTR_W'(N_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = winner + PTR_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register; only reset clears it, so it survives IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rng_arbiter.sv
// Sequences the external LFSR through IDLE -> WARMUP -> RUN, discards the
// post-reseed words, and hands at most one random word per cycle to the
// requesters in round-robin order. All outputs come straight from flops.
module rng_arbiter
  import rng_pkg::*;
#(
  parameter int unsigned N_REQ      = DEF_N_REQ,
  parameter int unsigned LFSR_LEN   = DEF_LFSR_LEN,
  parameter int unsigned RAND_W     = DEF_RAND_W,
  parameter int unsigned WARMUP_CYC = DEF_WARMUP_CYC,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run_en,
  output logic                lfsr_en,
  input  logic [LFSR_LEN-1:0] lfsr_out,
  input  logic [N_REQ-1:0]    req,
  output logic [N_REQ-1:0]    gnt,
  output logic [RAND_W-1:0]   rand_data,
  output logic                rand_valid,
  output logic                busy,
  output logic                warm,
  output logic [CNT_W-1:0]    issued_cnt
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  state_e              state_q, state_d;
  logic [7:0]          wcnt_q, wcnt_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [RAND_W-1:0]   rand_data_q, rand_data_d;
  logic                rand_valid_q, rand_valid_d;
  logic                lfsr_en_q, lfsr_en_d;
  logic                busy_q, busy_d;
  logic                warm_q, warm_d;
  logic [CNT_W-1:0]    issued_cnt_q, issued_cnt_d;

  logic [N_REQ-1:0]    eligible_s;
  logic                any_s;
  logic [PTR_W-1:0]    win_s;
  logic                grant_s;

  // Last cycle's winner sits out one edge, giving it time to drop req.
  assign eligible_s = req & ~gnt_q;
  // A grant is only made in RUN and never on the edge that leaves RUN.
  assign grant_s    = (state_q == RUN) && run_en && any_s;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_mask (eligible_s),
    .take     (grant_s),
    .any_req  (any_s),
    .winner   (win_s)
  );

  // Next-state logic and warmup counting.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (run_en) begin
          state_d = WARMUP;
          wcnt_d  = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      WARMUP: begin
        if (!run_en) begin
          state_d = IDLE;
        end else if (wcnt_q == 8'(WARMUP_CYC - 1)) begin
          state_d = RUN;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      RUN: begin
        if (!run_en) begin
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = 8'd0;
      end
    endcase
  end

  // Grant, data capture, issue count and status outputs for the next edge.
  always_comb begin
    gnt_d        = '0;
    rand_data_d  = rand_data_q;
    issued_cnt_d = issued_cnt_q;
    if (grant_s) begin
      gnt_d        = {{(N_REQ-1){1'b0}}, 1'b1} << win_s;
      rand_data_d  = lfsr_out[RAND_W-1:0];
      issued_cnt_d = issued_cnt_q + CNT_W'(1);
    end else begin
      gnt_d = '0;
    end
    rand_valid_d = |gnt_d;
    lfsr_en_d    = (state_d != IDLE);
    busy_d       = (state_d != IDLE);
    warm_d       = (state_d == RUN);
  end

  // State, counters and output registers with immediate asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wcnt_q       <= 8'd0;
      gnt_q        <= '0;
      rand_data_q  <= '0;
      rand_valid_q <= 1'b0;
      lfsr_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      warm_q       <= 1'b0;
      issued_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      gnt_q        <= gnt_d;
      rand_data_q  <= rand_data_d;
      rand_valid_q <= rand_valid_d;
      lfsr_en_q    <= lfsr_en_d;
      busy_q       <= busy_d;
      warm_q       <= warm_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end

  assign gnt        = gnt_q;
  assign rand_data  = rand_data_q;
  assign rand_valid = rand_valid_q;
  assign lfsr_en    = lfsr_en_q;
  assign busy       = busy_q;
  assign warm       = warm_q;
  assign issued_cnt = issued_cnt_q;

endmodule
